// File: rtl/sb_dcache_port_arbiter.sv
// sb_dcache_port_arbiter
// Arbitrates the single L1-D cache port between speculative loads and the
// retired store-buffer head, sequences the req/ready/done handshake, and
// pops the store-buffer head after every completed store write.
//
// Ports
//   CLK, RST                     clock, asynchronous active-high reset
//   ld_req, ld_addr              load request (held until ld_grant)
//   ld_grant, ld_valid, ld_data  load accept pulse, result pulse, result data
//   flush                        speculative squash of the in-flight load
//   sb_head_valid/addr/data      retired store-buffer head
//   sb_stall                     store buffer nearly full, forces a drain
//   sb_pop_head                  pulse: head written, advance it
//   dc_req, dc_we, dc_addr,
//   dc_wdata                     cache request channel
//   dc_ready, dc_done, dc_rdata  cache accept / completion / read data
module sb_dcache_port_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_grant,
   output logic              ld_valid,
   output logic [DATA_W-1:0] ld_data,
   input  logic              flush,
   input  logic              sb_head_valid,
   input  logic [ADDR_W-1:0] sb_head_addr,
   input  logic [DATA_W-1:0] sb_head_data,
   input  logic              sb_stall,
   output logic              sb_pop_head,
   output logic              dc_req,
   output logic              dc_we,
   output logic [ADDR_W-1:0] dc_addr,
   output logic [DATA_W-1:0] dc_wdata,
   input  logic              dc_ready,
   input  logic              dc_done,
   input  logic [DATA_W-1:0] dc_rdata
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_REQ  = 3'd1,
      LD_WAIT = 3'd2,
      ST_REQ  = 3'd3,
      ST_WAIT = 3'd4,
      ST_POP  = 3'd5
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             squashed;

   // Selection terms, only consumed in IDLE.
   logic force_st_c;
   logic ld_ok_c;
   assign force_st_c = sb_head_valid && (sb_stall || (starve_cnt == STARVE_LIM));
   assign ld_ok_c    = ld_req && !flush;

   // Arbitration FSM with registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         squashed    <= 1'b0;
         ld_grant    <= 1'b0;
         ld_valid    <= 1'b0;
         ld_data     <= '0;
         sb_pop_head <= 1'b0;
         dc_req      <= 1'b0;
         dc_we       <= 1'b0;
         dc_addr     <= '0;
         dc_wdata    <= '0;
      end else begin
         // Pulse outputs default low.
         ld_grant    <= 1'b0;
         ld_valid    <= 1'b0;
         sb_pop_head <= 1'b0;

         case (state)
            IDLE: begin
               if (force_st_c || (!ld_ok_c && sb_head_valid)) begin
                  state      <= ST_REQ;
                  dc_req     <= 1'b1;
                  dc_we      <= 1'b1;
                  dc_addr    <= sb_head_addr;
                  dc_wdata   <= sb_head_data;
                  starve_cnt <= '0;
               end else if (ld_ok_c) begin
                  state    <= LD_REQ;
                  dc_req   <= 1'b1;
                  dc_we    <= 1'b0;
                  dc_addr  <= ld_addr;
                  ld_grant <= 1'b1;
                  squashed <= 1'b0;
                  // Loads passing over a pending store count toward starvation.
                  if (sb_head_valid && (starve_cnt != STARVE_LIM)) begin
                     starve_cnt <= starve_cnt + CNT_W'(1);
                  end
               end
            end

            LD_REQ: begin
               if (flush) begin
                  squashed <= 1'b1;
               end
               if (dc_ready) begin
                  dc_req <= 1'b0;
                  state  <= LD_WAIT;
               end
            end

            LD_WAIT: begin
               if (dc_done) begin
                  // Data is captured even when squashed; only the valid pulse is dropped.
                  ld_data  <= dc_rdata;
                  ld_valid <= !(squashed || flush);
                  squashed <= 1'b0;
                  state    <= IDLE;
               end else if (flush) begin
                  squashed <= 1'b1;
               end
            end

            ST_REQ: begin
               if (dc_ready) begin
                  dc_req <= 1'b0;
                  state  <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (dc_done) begin
                  sb_pop_head <= 1'b1;
                  state       <= ST_POP;
               end
            end

            ST_POP: begin
               // Head advances on this edge, so IDLE sees the next entry.
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sb_dcache_port_arbiter.sv
// Self-checking bench for sb_dcache_port_arbiter: a transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sb_dcache_port_arbiter;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned STARVE_MAX = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              ld_req = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic              ld_grant;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              flush = 1'b0;
   logic              sb_head_valid = 1'b0;
   logic [ADDR_W-1:0] sb_head_addr = '0;
   logic [DATA_W-1:0] sb_head_data = '0;
   logic              sb_stall = 1'b0;
   logic              sb_pop_head;
   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic              dc_ready = 1'b0;
   logic              dc_done = 1'b0;
   logic [DATA_W-1:0] dc_rdata = '0;

   int checks   = 0;
   int failures = 0;

   sb_dcache_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .CLK(CLK), .RST(RST),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant),
      .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
      .sb_head_valid(sb_head_valid), .sb_head_addr(sb_head_addr),
      .sb_head_data(sb_head_data), .sb_stall(sb_stall),
      .sb_pop_head(sb_pop_head), .dc_req(dc_req), .dc_we(dc_we),
      .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_ready(dc_ready),
      .dc_done(dc_done), .dc_rdata(dc_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // One transaction at a time: busy while the port is owned; acc once the
   // cache accepted the request; popping for the cycle after a store completes.
   logic              m_busy = 0, m_store = 0, m_acc = 0, m_popping = 0, m_squash = 0;
   int                m_starve = 0;
   logic              e_req = 0, e_we = 0, e_grant = 0, e_valid = 0, e_pop = 0;
   logic [ADDR_W-1:0] e_addr = '0;
   logic [DATA_W-1:0] e_wdata = '0;
   logic [DATA_W-1:0] e_data = '0;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_busy <= 0; m_store <= 0; m_acc <= 0; m_popping <= 0; m_squash <= 0;
         m_starve <= 0;
         e_req <= 0; e_we <= 0; e_grant <= 0; e_valid <= 0; e_pop <= 0;
         e_addr <= '0; e_wdata <= '0; e_data <= '0;
      end else begin
         e_grant <= 0; e_valid <= 0; e_pop <= 0;
         if (!m_busy) begin
            if (sb_head_valid && (sb_stall || m_starve == int'(STARVE_MAX))) begin
               m_busy <= 1; m_store <= 1; m_acc <= 0; m_popping <= 0;
               e_req <= 1; e_we <= 1; e_addr <= sb_head_addr; e_wdata <= sb_head_data;
               m_starve <= 0;
            end else if (ld_req && !flush) begin
               m_busy <= 1; m_store <= 0; m_acc <= 0; m_squash <= 0;
               e_req <= 1; e_we <= 0; e_addr <= ld_addr; e_grant <= 1;
               if (sb_head_valid && m_starve < int'(STARVE_MAX)) m_starve <= m_starve + 1;
            end else if (sb_head_valid) begin
               m_busy <= 1; m_store <= 1; m_acc <= 0; m_popping <= 0;
               e_req <= 1; e_we <= 1; e_addr <= sb_head_addr; e_wdata <= sb_head_data;
               m_starve <= 0;
            end
         end else if (!m_acc) begin
            if (!m_store && flush) m_squash <= 1;
            if (dc_ready) begin
               m_acc <= 1; e_req <= 0;
            end
         end else if (!m_store) begin
            if (dc_done) begin
               e_data <= dc_rdata; e_valid <= !(m_squash || flush); m_busy <= 0;
            end else if (flush) begin
               m_squash <= 1;
            end
         end else if (m_popping) begin
            m_busy <= 0;
         end else if (dc_done) begin
            e_pop <= 1; m_popping <= 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      chk("m_dc_req", 32'(dc_req), 32'(e_req));
      chk("m_dc_we", 32'(dc_we), 32'(e_we));
      chk("m_dc_addr", 32'(dc_addr), 32'(e_addr));
      if (e_we) chk("m_dc_wdata", 32'(dc_wdata), 32'(e_wdata));
      chk("m_ld_grant", 32'(ld_grant), 32'(e_grant));
      chk("m_ld_valid", 32'(ld_valid), 32'(e_valid));
      chk("m_ld_data", 32'(ld_data), 32'(e_data));
      chk("m_sb_pop", 32'(sb_pop_head), 32'(e_pop));
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [7:0] ev[$];
      RST = 1'b1;
      step(); step();
      chk("rst_dc_req", 32'(dc_req), 0);
      chk("rst_ld_data", 32'(ld_data), 0);
      chk("rst_dc_addr", 32'(dc_addr), 0);
      RST = 1'b0;
      step();

      // Basic load.
      ld_req = 1; ld_addr = 16'h1234; dc_ready = 1;
      step();
      chk("ld_grant", 32'(ld_grant), 1);
      chk("ld_addr", 32'(dc_addr), 32'h1234);
      chk("ld_we", 32'(dc_we), 0);
      ld_req = 0;
      step();
      chk("ld_grant_pulse", 32'(ld_grant), 0);
      dc_ready = 0;
      step();
      dc_done = 1; dc_rdata = 16'hBEEF;
      step();
      chk("ld_valid", 32'(ld_valid), 1);
      chk("ld_data", 32'(ld_data), 32'hBEEF);
      dc_done = 0;
      step();
      chk("ld_valid_pulse", 32'(ld_valid), 0);

      // Store with delayed ready.
      sb_head_valid = 1; sb_head_addr = 16'h0040; sb_head_data = 16'h5A5A;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_req_held", 32'(dc_req), 1);
         chk("st_we", 32'(dc_we), 1);
         chk("st_wdata", 32'(dc_wdata), 32'h5A5A);
      end
      dc_ready = 1;
      step();
      chk("st_req_drop", 32'(dc_req), 0);
      dc_ready = 0; dc_done = 1;
      step();
      chk("st_pop", 32'(sb_pop_head), 1);
      sb_head_valid = 0; dc_done = 0;
      step();
      chk("st_pop_pulse", 32'(sb_pop_head), 0);
      step();
      chk("st_idle_stay", 32'(dc_req), 0);

      // Starvation: continuous loads with a pending head, cache always answering.
      ld_req = 1; sb_head_valid = 1; sb_head_addr = 16'h0060; sb_head_data = 16'h0F0F;
      dc_ready = 1; dc_done = 1; dc_rdata = 16'h0101;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ld_grant) ev.push_back("L");
         if (sb_pop_head) ev.push_back("S");
      end
      chk("starve_evcount_ge10", 32'(ev.size() >= 10), 1);
      for (int i = 0; i < 10 && i < ev.size(); i++) begin
         chk("starve_order", 32'(ev[i]), (i % 5 == 4) ? 32'("S") : 32'("L"));
      end
      ld_req = 0; sb_head_valid = 0;
      repeat (5) step();
      dc_ready = 0; dc_done = 0;
      step();

      // Stall forces the store ahead of a waiting load.
      ld_req = 1; ld_addr = 16'h4444;
      sb_head_valid = 1; sb_stall = 1; sb_head_addr = 16'h0100; sb_head_data = 16'hA5A5;
      dc_ready = 1;
      step();
      chk("stall_st_we", 32'(dc_we), 1);
      chk("stall_no_grant", 32'(ld_grant), 0);
      chk("stall_addr", 32'(dc_addr), 32'h0100);
      step();
      dc_done = 1;
      step();
      chk("stall_pop", 32'(sb_pop_head), 1);
      sb_head_valid = 0; sb_stall = 0; dc_done = 0;
      step();
      chk("stall_ld_wait", 32'(ld_grant), 0);
      step();
      chk("stall_ld_grant", 32'(ld_grant), 1);
      chk("stall_ld_addr", 32'(dc_addr), 32'h4444);
      ld_req = 0;
      step();
      dc_ready = 0; dc_done = 1; dc_rdata = 16'h1111;
      step();
      chk("stall_ld_valid", 32'(ld_valid), 1);
      chk("stall_ld_data", 32'(ld_data), 32'h1111);
      dc_done = 0;
      step();

      // Flush during LD_WAIT squashes the result.
      ld_req = 1; ld_addr = 16'h2222; dc_ready = 1;
      step();
      ld_req = 0;
      step();
      dc_ready = 0; flush = 1;
      step();
      flush = 0; dc_done = 1; dc_rdata = 16'hDEAD;
      step();
      chk("flush_no_valid", 32'(ld_valid), 0);
      chk("flush_data_cap", 32'(ld_data), 32'hDEAD);
      dc_done = 0;
      step();
      chk("flush_no_valid2", 32'(ld_valid), 0);

      // ld_req with flush in IDLE is not selected; next load returns normally.
      ld_req = 1; ld_addr = 16'h3333; flush = 1;
      step();
      chk("flush_idle_nogrant", 32'(ld_grant), 0);
      chk("flush_idle_noreq", 32'(dc_req), 0);
      flush = 0; dc_ready = 1;
      step();
      chk("post_flush_grant", 32'(ld_grant), 1);
      ld_req = 0;
      step();
      dc_ready = 0; dc_done = 1; dc_rdata = 16'h7777;
      step();
      chk("post_flush_valid", 32'(ld_valid), 1);
      chk("post_flush_data", 32'(ld_data), 32'h7777);
      dc_done = 0;
      step();

      // Reset during ST_WAIT aborts with no pop.
      sb_head_valid = 1; sb_head_addr = 16'h0080; sb_head_data = 16'h1357; dc_ready = 1;
      step();
      step();
      dc_ready = 0;
      RST = 1;
      #1;
      chk("rst_mid_req", 32'(dc_req), 0);
      chk("rst_mid_we", 32'(dc_we), 0);
      chk("rst_mid_addr", 32'(dc_addr), 0);
      chk("rst_mid_wdata", 32'(dc_wdata), 0);
      dc_done = 1;
      step();
      chk("rst_mid_pop", 32'(sb_pop_head), 0);
      sb_head_valid = 0;
      RST = 0;
      step();
      chk("rst_rel_pop", 32'(sb_pop_head), 0);
      chk("rst_rel_req", 32'(dc_req), 0);
      dc_done = 0;
      step();
      chk("rst_rel_idle", 32'(dc_req), 0);
      chk("rst_rel_pop2", 32'(sb_pop_head), 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sb_dcache_port_arbiter.md
# sb_dcache_port_arbiter

Single-port L1-D access controller between the load/store stage and the store buffer. Each cycle it is idle, it decides whether the one cache port serves a speculative load or drains the retired store-buffer head. It sequences the cache request/ready/done handshake and pulses `sb_pop_head` after each completed store write. Store drain is forced when the store buffer signals stall or loads have starved stores for `STARVE_MAX` grants in a row.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `STARVE_MAX`, 4, consecutive load grants allowed while a store head is pending (1..7)

- `CLK`  in  1  clock
- `RST`  in  1  reset, asynchronous, active-high
- `ld_req`  in  1  load wants cache; held with `ld_addr` stable until `ld_grant`
- `ld_addr`  in  ADDR_W  load address
- `ld_grant`  out  1  one-cycle pulse: load accepted
- `ld_valid`  out  1  one-cycle pulse: `ld_data` valid
- `ld_data`  out  DATA_W  load result
- `flush`  in  1  speculative squash (store buffer `clear_speculative`)
- `sb_head_valid`  in  1  store-buffer head is valid, executed and retired
- `sb_head_addr`  in  ADDR_W  head address
- `sb_head_data`  in  DATA_W  head data
- `sb_stall`  in  1  store buffer nearly full
- `sb_pop_head`  out  1  one-cycle pulse: head written, pop it
- `dc_req`  out  1  cache request
- `dc_we`  out  1  1 = write (store), 0 = read (load)
- `dc_addr`  out  ADDR_W  request address
- `dc_wdata`  out  DATA_W  write data
- `dc_ready`  in  1  cache accepts request this cycle
- `dc_done`  in  1  write complete / read data valid
- `dc_rdata`  in  DATA_W  read data

## Operation
- States: IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT, ST_POP.
- Selection happens in IDLE only. `force_st` = `sb_head_valid` and (`sb_stall` or `starve_cnt` == `STARVE_MAX`).
  - If `force_st`: go to ST_REQ.
  - Else if `ld_req` and not `flush`: go to LD_REQ.
  - Else if `sb_head_valid`: go to ST_REQ.
  - Otherwise stay in IDLE.
- On the IDLE exit edge, register `dc_addr`, `dc_wdata` and `dc_we` from the selected source. They stay constant through the transaction.
- LD_REQ / ST_REQ:
  - `dc_req`=1 every cycle until `dc_ready`=1, then go to LD_WAIT / ST_WAIT.
  - `ld_grant`=1 only in the first LD_REQ cycle.
- LD_WAIT, on `dc_done`:
  - Capture `dc_rdata` into `ld_data`.
  - `ld_valid`=1 next cycle unless the load was squashed.
  - Go to IDLE.
- ST_WAIT, on `dc_done`: go to ST_POP.
- ST_POP: `sb_pop_head`=1 for exactly this cycle, then IDLE. The head advances on the ST_POP exit edge, so IDLE never reissues the same entry.
- `flush` during LD_REQ or LD_WAIT:
  - Set a `squashed` flag. The cache transaction still completes.
  - `ld_valid` is suppressed for that load.
  - `squashed` clears on return to IDLE.
- `flush` never affects store states, because drained stores are retired.
- `starve_cnt` (3 bits):
  - +1 when a load is selected while `sb_head_valid`=1, saturating at `STARVE_MAX`.
  - Cleared when a store is selected.
  - Unchanged when a load is selected with no pending head.
- `dc_done` outside the WAIT states is ignored.

## Timing
- Reset state:
  - State IDLE, `starve_cnt`=0, `squashed`=0.
  - Outputs `dc_req`, `dc_we`, `ld_grant`, `ld_valid` and `sb_pop_head` are 0.
  - `dc_addr`, `dc_wdata` and `ld_data` are 0.
- RST asserted mid-transaction aborts immediately to the reset state. No pop, no `ld_valid`.
- Load path:
  - Decision in cycle t gives `dc_req` and `ld_grant` in t+1.
  - `dc_ready` at t+1 puts the FSM in LD_WAIT at t+2.
  - `dc_done` at cycle k gives `ld_valid` at k+1.
  - Minimum 3 cycles decision to `ld_valid`.
- Store path: decision t; `dc_req` t+1; ready t+1; done at t+2 or later; pop at done+1; IDLE at done+2. Minimum 4 cycles.
- At most one outstanding cache transaction. Back-to-back transactions have one IDLE cycle between them.
- Simultaneous `ld_req`, `sb_head_valid` and `sb_stall`: the store wins and the load waits with `ld_req` held.
- Simultaneous `ld_req` and `flush` in IDLE: the load is not selected.

## Test plan
- Reset, then `ld_req`=1 with `ld_addr`=0x1234, `dc_ready`=1, `dc_done` two cycles later with `dc_rdata`=0xBEEF.
  - Expect `ld_grant` 1 cycle after the request and `dc_addr`=0x1234, `dc_we`=0.
  - Expect `ld_valid`=1 with `ld_data`=0xBEEF one cycle after done.
- `sb_head_valid`=1, addr 0x0040, data 0x5A5A, `dc_ready` delayed 3 cycles.
  - Expect `dc_req` held 3 cycles with `dc_we`=1, `dc_wdata`=0x5A5A.
  - Expect `sb_pop_head` a single pulse after `dc_done`; drop head valid → FSM stays IDLE.
- Continuous `ld_req` plus `sb_head_valid`, `STARVE_MAX`=4.
  - Expect 4 load grants, then 1 store, then loads resume with `starve_cnt` back to 0.
- `sb_stall`=1 with `ld_req` and head both valid → expect the store selected first.
- `flush` in LD_WAIT → `dc_done` is consumed and `ld_valid` stays 0; the next load returns normally.
- RST pulse during ST_WAIT → expect all outputs 0, no `sb_pop_head`, and state IDLE on release.
